// File: rtl/param_instruction_memory.sv
// Instruction RAM filled by an auto-incrementing loader, read by byte PC with fault reporting.
// Fetch latency 1 cycle; fetch_stall freezes the fetch outputs, load_ready/fetch_ready gate the ports by mode.
module param_instruction_memory #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 7,
    parameter int                    PC_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    // image loader
    input  logic                  load_start,
    input  logic                  load_valid,
    input  logic                  load_last,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_ready,
    output logic [ADDR_WIDTH:0]   load_count,
    // fetch port
    output logic                  fetch_ready,
    input  logic                  fetch_req,
    input  logic [PC_WIDTH-1:0]   fetch_pc,
    input  logic                  fetch_stall,
    output logic [DATA_WIDTH-1:0] instr,
    output logic                  instr_valid,
    output logic                  addr_fault
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] CNT_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] CNT_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  wr_en;
    logic                  wr_ends_image;
    logic [ADDR_WIDTH:0]   load_count_nxt;
    logic                  fetch_acc;
    logic [ADDR_WIDTH-1:0] fetch_idx;
    logic                  pc_hi_set;
    logic                  fetch_fault;

    assign load_ready  = (state == S_LOAD);
    assign fetch_ready = (state == S_RUN);

    // load_start wins over a same-cycle load_valid; the word is dropped.
    assign wr_en         = load_ready & load_valid & ~load_start & (load_count != CNT_FULL);
    assign wr_ends_image = load_last | (load_count == CNT_LAST);

    always_comb begin
        state_nxt      = state;
        load_count_nxt = load_count;
        if (load_start) begin
            load_count_nxt = '0;
        end else if (wr_en) begin
            load_count_nxt = load_count + 1'b1;
        end
        case (state)
            S_IDLE: if (load_start) state_nxt = S_LOAD;
            S_LOAD: if (!load_start && wr_en && wr_ends_image) state_nxt = S_RUN;
            S_RUN:  if (load_start) state_nxt = S_LOAD;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            load_count <= '0;
        end else begin
            state      <= state_nxt;
            load_count <= load_count_nxt;
        end
    end

    // Array deliberately has no reset: the image survives reset, load_count guards it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[load_count[ADDR_WIDTH-1:0]] <= load_data;
        end
    end

    assign fetch_acc = fetch_ready & fetch_req & ~fetch_stall;
    assign fetch_idx = fetch_pc[ADDR_WIDTH+1:2];

    generate
        if (PC_WIDTH > ADDR_WIDTH + 2) begin : g_pc_hi
            assign pc_hi_set = |fetch_pc[PC_WIDTH-1:ADDR_WIDTH+2];
        end else begin : g_no_pc_hi
            assign pc_hi_set = 1'b0;
        end
    endgenerate

    assign fetch_fault = (fetch_pc[1:0] != 2'b00) | pc_hi_set |
                         ({1'b0, fetch_idx} >= load_count);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr       <= '0;
            instr_valid <= 1'b0;
            addr_fault  <= 1'b0;
        end else if (!fetch_stall) begin
            if (fetch_acc) begin
                instr       <= fetch_fault ? FILL_WORD : mem[fetch_idx];
                instr_valid <= 1'b1;
                addr_fault  <= fetch_fault;
            end else begin
                instr_valid <= 1'b0;
                addr_fault  <= 1'b0;
            end
        end
    end

endmodule
